// File: rtl/instr_queue_player.sv
// Instruction queue for the robot: save/delete edit a LIFO-trimmed list, execute replays it
// as registered motor commands (1-cycle latency), each entry held STEP_CYCLES clocks.
module instr_queue_player #(
    parameter int DEPTH       = 8,
    parameter int STEP_CYCLES = 50_000_000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       save,
    input  logic                       execute,
    input  logic                       delete,
    input  logic [3:0]                 instr_in,
    output logic                       cmd_valid,
    output logic [1:0]                 cmd_dir,
    output logic [1:0]                 cmd_torque,
    output logic [$clog2(DEPTH)-1:0]   step_index,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       busy,
    output logic                       full,
    output logic                       empty
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    // A single-cycle step still needs a one-bit timer to exist.
    localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [3:0]     mem [DEPTH];
    logic [TW-1:0]  timer;
    logic           start;
    logic           step_done;
    logic           last_step;

    assign busy      = (state == RUN);
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign start     = execute && !empty;
    assign step_done = (timer == TW'(STEP_CYCLES - 1));
    assign last_step = ((CW'(step_index) + CW'(1)) == count);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (step_done && last_step) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            timer      <= '0;
            step_index <= '0;
            cmd_valid  <= 1'b0;
            cmd_dir    <= 2'b00;
            cmd_torque <= 2'b00;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        timer                   <= '0;
                        step_index              <= '0;
                        cmd_valid               <= 1'b1;
                        {cmd_torque, cmd_dir}   <= mem[0];
                    end else if (save && delete) begin
                        count <= count;
                    end else if (save && !full) begin
                        mem[count[IW-1:0]] <= instr_in;
                        count              <= count + 1'b1;
                    end else if (delete && !empty) begin
                        count <= count - 1'b1;
                    end
                end
                RUN: begin
                    // Queue is frozen here; edits and execute are ignored.
                    if (step_done) begin
                        timer <= '0;
                        if (last_step) begin
                            step_index <= '0;
                            cmd_valid  <= 1'b0;
                            cmd_dir    <= 2'b00;
                            cmd_torque <= 2'b00;
                        end else begin
                            step_index            <= step_index + 1'b1;
                            {cmd_torque, cmd_dir} <= mem[step_index + 1'b1];
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_queue_player.sv
// Directed bench for instr_queue_player: per-cycle compare against a list/playback-position model.
module tb_instr_queue_player;
    localparam int DEPTH = 4;
    localparam int STEP  = 4;

    logic       clk = 1'b0;
    logic       reset, save, execute, delete;
    logic [3:0] instr_in;
    logic       cmd_valid, busy, full, empty;
    logic [1:0] cmd_dir, cmd_torque;
    logic [1:0] step_index;
    logic [2:0] count;

    int total = 0;
    int bad   = 0;

    // Model: stored list plus a playback position in cycles (-1 when idle)
    int  m_mem [DEPTH];
    int  m_cnt  = 0;
    int  m_play = -1;
    bit  m_ok   = 0;

    int vlog [32];
    int tlog [32];
    int dlog [32];

    instr_queue_player #(.DEPTH(DEPTH), .STEP_CYCLES(STEP)) dut (
        .clk(clk), .reset(reset), .save(save), .execute(execute), .delete(delete),
        .instr_in(instr_in), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
        .cmd_torque(cmd_torque), .step_index(step_index), .count(count),
        .busy(busy), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_cnt = 0; m_play = -1; m_ok = 1;
        end else if (m_play >= 0) begin
            m_play++;
            if (m_play == m_cnt * STEP) m_play = -1;
        end else if (execute && m_cnt > 0) begin
            m_play = 0;
        end else if (save && delete) begin
            m_play = -1;
        end else if (save) begin
            if (m_cnt < DEPTH) begin
                m_mem[m_cnt] = int'(instr_in);
                m_cnt++;
            end
        end else if (delete && m_cnt > 0) begin
            m_cnt--;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            int idx, ent;
            idx = (m_play >= 0) ? m_play / STEP : 0;
            ent = (m_play >= 0) ? m_mem[idx] : 0;
            check("cmd_valid",  int'(cmd_valid),  int'(m_play >= 0));
            check("busy",       int'(busy),       int'(m_play >= 0));
            check("cmd_torque", int'(cmd_torque), ent / 4);
            check("cmd_dir",    int'(cmd_dir),    ent % 4);
            check("step_index", int'(step_index), idx);
            check("count",      int'(count),      m_cnt);
            check("full",       int'(full),       int'(m_cnt == DEPTH));
            check("empty",      int'(empty),      int'(m_cnt == 0));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle pulse; returns at the negedge right after the sampling edge.
    task automatic pulse(input logic s, input logic e, input logic d, input logic [3:0] v);
        @(negedge clk);
        save = s; execute = e; delete = d; instr_in = v;
        @(negedge clk);
        save = 0; execute = 0; delete = 0;
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            vlog[i] = int'(cmd_valid);
            tlog[i] = int'(cmd_torque);
            dlog[i] = int'(cmd_dir);
            @(negedge clk);
        end
    endtask

    function automatic int sum_valid(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += vlog[i];
        return s;
    endfunction

    initial begin
        logic [3:0] t1 [5];
        t1[0] = 4'b0000; t1[1] = 4'b0100; t1[2] = 4'b1000; t1[3] = 4'b1100; t1[4] = 4'b1110;
        reset = 1; save = 0; execute = 0; delete = 0; instr_in = 0;
        tick(3);
        reset = 0;
        @(negedge clk);
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_valid", int'(cmd_valid), 0);

        // 1: fill past capacity
        for (int i = 0; i < 5; i++) begin
            pulse(1, 0, 0, t1[i]);
            tick(3);
        end
        check("t1_count", int'(count), 4);
        check("t1_full",  int'(full), 1);
        check("t1_empty", int'(empty), 0);

        // 2: full playback
        pulse(0, 1, 0, 0);
        capture(18);
        check("t2_valid_cycles", sum_valid(18), 16);
        check("t2_first_valid", vlog[0], 1);
        check("t2_torque0", tlog[0], 0);
        check("t2_torque1", tlog[4], 1);
        check("t2_torque2", tlog[8], 2);
        check("t2_torque3", tlog[15], 3);
        check("t2_dir", dlog[13], 0);
        check("t2_after_valid", vlog[16], 0);
        check("t2_count_kept", int'(count), 4);

        // 3: trim two and replay
        pulse(0, 0, 1, 0);
        pulse(0, 0, 1, 0);
        check("t3_count", int'(count), 2);
        pulse(0, 1, 0, 0);
        capture(10);
        check("t3_valid_cycles", sum_valid(10), 8);
        check("t3_torque0", tlog[3], 0);
        check("t3_torque1", tlog[4], 1);
        check("t3_after_valid", vlog[8], 0);

        // 4: edits ignored during RUN, execute on empty ignored
        pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 4'b1111);
        pulse(0, 0, 1, 0);
        check("t4_run_count", int'(count), 2);
        check("t4_run_busy", int'(busy), 1);
        tick(8);
        pulse(0, 0, 1, 0);
        pulse(0, 0, 1, 0);
        check("t4_empty", int'(empty), 1);
        pulse(0, 1, 0, 0);
        check("t4_exec_empty_busy", int'(busy), 0);
        tick(1);
        check("t4_exec_empty_valid", int'(cmd_valid), 0);

        // 5: reset in the middle of a 4-entry playback
        pulse(1, 0, 0, 4'b0011);
        pulse(1, 0, 0, 4'b0110);
        pulse(1, 0, 0, 4'b1001);
        pulse(1, 0, 0, 4'b1111);
        pulse(0, 1, 0, 0);
        check("t5_first_dir", int'(cmd_dir), 3);
        tick(5);
        check("t5_mid_torque", int'(cmd_torque), 1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("t5_valid", int'(cmd_valid), 0);
        check("t5_busy", int'(busy), 0);
        check("t5_count", int'(count), 0);
        check("t5_empty", int'(empty), 1);
        check("t5_step", int'(step_index), 0);

        // 6: simultaneous commands
        pulse(1, 0, 0, 4'b0001);
        pulse(1, 0, 0, 4'b0110);
        pulse(1, 0, 1, 4'b1010);
        check("t6_save_del_count", int'(count), 2);
        pulse(1, 1, 0, 4'b1111);
        check("t6_exec_save_busy", int'(busy), 1);
        check("t6_exec_save_count", int'(count), 2);
        capture(10);
        check("t6_valid_cycles", sum_valid(10), 8);
        check("t6_count_after", int'(count), 2);
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
